// File: rtl/breath_pkg.sv
// Shared types and defaults for the LED breath envelope generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package breath_pkg;

    // FSM state; the encoding is exported on phaseO and must stay fixed.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    // Default duty word width: ramp spans 0..2047.
    localparam int DEF_WIDTH = 11;

    // Default clkI cycles per ramp step at 12 MHz (12e6 / 2048 steps/s).
    localparam int DEF_STEP_DIV = 5859;

endpackage

// File: rtl/breath_tick.sv
// Ramp-step prescaler: one-cycle tickO every STEP_DIV clkI cycles.
// Latency: tickO is combinational from the counter; first tick STEP_DIV-1 cycles after clrI drops.
// Backpressure: none; clrI holds the counter at 0 for as long as it is high.
module breath_tick
    import breath_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic clkI,
    input  logic rstI,
    input  logic clrI,
    output logic tickO
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running 0..STEP_DIV-1 counter, parked at 0 while cleared.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            cnt <= '0;
        end else if (clrI || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tickO = (cnt == LAST) && !clrI;

endmodule

// File: rtl/breath_envelope.sv
// Triangular breath envelope (duty word) for the LED PWM comparator; BREATH_GAMMA_EN selects a squared-law output.
// Latency: dutyO/updO change one cycle after the tick edge that moves the ramp.
// Backpressure: none; enI is level-sensitive and dropping it always ramps down to 0 before IDLE.
module breath_envelope
    import breath_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int HOLD_STEPS = 0
) (
    input  logic             clkI,
    input  logic             rstI,
    input  logic             enI,
    output logic [WIDTH-1:0] dutyO,
    output logic             updO,
    output logic [2:0]       phaseO,
    output logic             activeO
);

    localparam logic [WIDTH-1:0] LIN_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LIN_PRE = LIN_MAX - WIDTH'(1);
    localparam int               HW        = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_STEPS);
    localparam bit               HOLD_EN   = (HOLD_STEPS > 0);

    state_t           state, state_n;
    logic [WIDTH-1:0] lin, lin_n;
    logic [WIDTH-1:0] duty_n;
    logic [HW-1:0]    hold, hold_n;
    logic             tick;

    breath_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clkI  (clkI),
        .rstI  (rstI),
        .clrI  (state == IDLE),
        .tickO (tick)
    );

    // Next state, ramp value and dwell counter; everything except IDLE exit waits for a tick.
    always_comb begin
        state_n = state;
        lin_n   = lin;
        hold_n  = hold;
        case (state)
            IDLE: begin
                lin_n  = '0;
                hold_n = '0;
                if (enI) state_n = RISE;
            end
            RISE: begin
                if (tick) begin
                    if (!enI) begin
                        // Stop request freezes lin for this tick; at 0 there is nothing to descend.
                        state_n = (lin == '0) ? IDLE : FALL;
                    end else begin
                        lin_n = lin + WIDTH'(1);
                        if (lin == LIN_PRE) begin
                            if (HOLD_EN) begin
                                state_n = HOLD_HI;
                                hold_n  = HOLD_LOAD;
                            end else begin
                                state_n = FALL;
                            end
                        end
                    end
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    hold_n = hold - HW'(1);
                    if (!enI || hold == HW'(1)) begin
                        state_n = FALL;
                        hold_n  = '0;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (lin == '0) begin
                        state_n = enI ? RISE : IDLE;
                    end else begin
                        lin_n = lin - WIDTH'(1);
                        if (lin == WIDTH'(1)) begin
                            if (!enI) begin
                                state_n = IDLE;
                            end else if (HOLD_EN) begin
                                state_n = HOLD_LO;
                                hold_n  = HOLD_LOAD;
                            end else begin
                                state_n = RISE;
                            end
                        end
                    end
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    hold_n = hold - HW'(1);
                    if (!enI) begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end else if (hold == HW'(1)) begin
                        state_n = RISE;
                        hold_n  = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                lin_n   = '0;
                hold_n  = '0;
            end
        endcase
    end

`ifdef BREATH_GAMMA_EN
    logic [2*WIDTH-1:0] sq;

    // Squared law from the next lin so the output register keeps the same latency.
    always_comb begin
        sq     = {{WIDTH{1'b0}}, lin_n} * {{WIDTH{1'b0}}, lin_n};
        duty_n = sq[2*WIDTH-1:WIDTH];
    end
`else
    assign duty_n = lin_n;
`endif

    // State, ramp and output registers; updO marks only real changes of the duty word.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state <= IDLE;
            lin   <= '0;
            hold  <= '0;
            dutyO <= '0;
            updO  <= 1'b0;
        end else begin
            state <= state_n;
            lin   <= lin_n;
            hold  <= hold_n;
            dutyO <= duty_n;
            updO  <= (duty_n != dutyO);
        end
    end

    assign phaseO  = state;
    assign activeO = (state != IDLE);

endmodule
